// File: rtl/memory_pkg.sv
// Shared definitions for the block-transfer main memory and its cache-side users.
// Holds the controller state type, geometry constants and the read/write type codes.
package memory_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StXfer,
    StDone
  } state_e;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned BLOCK_OFFSET_W  = 4;
  localparam int unsigned MEM_WORDS       = 256;

  localparam int unsigned WORD_IDX_W = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Storage is never reset; only the read register clears on reset.
module mem_array
  import memory_pkg::*;
#(
  parameter int unsigned Depth = MEM_WORDS,
  parameter int unsigned Width = DATA_W,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/block_memory.sv
// Main-memory stage serving whole 4-word block refills and write-backs for the data cache,
// with a programmable wait before the first word moves.
module block_memory
  import memory_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  r_w_type,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     write_data,
  output logic                  busy,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic [DATA_W-1:0]     read_data,
  output logic                  rvalid,
  output logic                  wready,
  output logic                  mem_done
);

  localparam int unsigned BlkW      = ADDR_W - BLOCK_OFFSET_W;
  localparam int unsigned WordAddrW = BlkW + WORD_IDX_W;
  localparam logic [WORD_IDX_W-1:0] LastWord = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BlkW-1:0]       blk_q, blk_d;
  logic                  rw_q, rw_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;

  logic busy_q, rvalid_q, wready_q, done_q;
  logic rd_en, wr_en;
  logic [WordAddrW-1:0] mem_addr;

  // Byte offset within the block plays no part in a whole-block transfer.
  logic unused_offset;
  assign unused_offset = ^addr[BLOCK_OFFSET_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    rw_d       = rw_q;
    word_idx_d = word_idx_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          blk_d   = addr[ADDR_W-1:BLOCK_OFFSET_W];
          rw_d    = r_w_type;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          word_idx_d = '0;
          state_d    = StXfer;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StXfer: begin
        if (word_idx_q == LastWord) begin
          state_d = StDone;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      blk_q      <= '0;
      rw_q       <= RW_READ;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      rw_q       <= rw_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q   <= (state_d != StIdle);
      rvalid_q <= (state_d == StXfer) && (rw_d == RW_READ);
      wready_q <= (state_d == StXfer) && (rw_d == RW_WRITE);
      done_q   <= (state_d == StDone);
    end
  end

  // Reads are issued one edge ahead so the registered word lands with its word_idx;
  // writes use the word currently being presented.
  always_comb begin
    rd_en    = (state_d == StXfer) && (rw_d == RW_READ);
    wr_en    = wready_q;
    mem_addr = wr_en ? {blk_q, word_idx_q} : {blk_q, word_idx_d};
  end

  mem_array #(
    .Depth (2 ** WordAddrW),
    .Width (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (rd_en | wr_en),
    .we    (wr_en),
    .addr  (mem_addr),
    .wdata (write_data),
    .rdata (read_data)
  );

  assign busy     = busy_q;
  assign word_idx = word_idx_q;
  assign rvalid   = rvalid_q;
  assign wready   = wready_q;
  assign mem_done = done_q;

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory: cycle-by-cycle protocol checks of every block
// transfer against a flat word-array model of the backing store.
module tb_block_memory;

  localparam int unsigned LAT = 4;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk;
  logic        reset;
  logic        req;
  logic        r_w_type;
  logic [9:0]  addr;
  logic [31:0] write_data;
  logic        busy;
  logic [1:0]  word_idx;
  logic [31:0] read_data;
  logic        rvalid;
  logic        wready;
  logic        mem_done;

  logic [31:0] model_mem [256];
  logic [31:0] wbuf [4];
  int vectors;
  int miscompares;

  block_memory #(
    .LATENCY (LAT),
    .ADDR_W  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .r_w_type   (r_w_type),
    .addr       (addr),
    .write_data (write_data),
    .busy       (busy),
    .word_idx   (word_idx),
    .read_data  (read_data),
    .rvalid     (rvalid),
    .wready     (wready),
    .mem_done   (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".rvalid"},    32'(rvalid),    32'd0);
    check({tag, ".wready"},    32'(wready),    32'd0);
    check({tag, ".mem_done"},  32'(mem_done),  32'd0);
    check({tag, ".word_idx"},  32'(word_idx),  32'd0);
    check({tag, ".read_data"}, read_data,      32'd0);
  endtask

  // One whole block transfer; entered and left just after a rising edge with the DUT idle.
  // abort_at >= 0 fires an asynchronous reset in the cycle that follows edge E0+abort_at.
  task automatic run_block(input logic rw, input logic [9:0] a, input bit hold,
                           input bit noise, input int abort_at);
    logic [7:0] base;
    int xi;
    bit in_xfer;
    base = {a[9:4], 2'b00};
    req = 1'b1;
    r_w_type = rw;
    addr = a;
    write_data = $urandom;
    @(posedge clk);
    #1;
    for (int k = 0; k <= int'(LAT) + 5; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      xi = k - int'(LAT);
      in_xfer = (xi >= 0) && (xi < 4);
      check("busy",     32'(busy),     32'(k <= int'(LAT) + 4));
      check("rvalid",   32'(rvalid),   32'(in_xfer && rw == RD));
      check("wready",   32'(wready),   32'(in_xfer && rw == WR));
      check("mem_done", 32'(mem_done), 32'(k == int'(LAT) + 4));
      if (in_xfer) check("word_idx", 32'(word_idx), 32'(xi));
      if (in_xfer && rw == RD) check("read_data", read_data, model_mem[base + 8'(xi)]);
      if (in_xfer) write_data = wbuf[xi];
      else write_data = $urandom;
      if (k == int'(LAT) + 5) begin
        req = hold;
      end else if (noise) begin
        req = 1'($urandom_range(0, 1));
        r_w_type = 1'($urandom_range(0, 1));
        addr = 10'($urandom);
      end else begin
        req = hold;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        if (rw == WR) begin
          for (int w = 0; w < 4; w++) begin
            if (w < xi) model_mem[base + 8'(w)] = wbuf[w];
          end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #1;
          check("post_abort.busy",     32'(busy),     32'd0);
          check("post_abort.mem_done", 32'(mem_done), 32'd0);
        end
        return;
      end
    end
    if (rw == WR) begin
      for (int w = 0; w < 4; w++) model_mem[base + 8'(w)] = wbuf[w];
    end
  endtask

  task automatic fill_wbuf_random();
    for (int w = 0; w < 4; w++) wbuf[w] = $urandom;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    reset = 1'b1;
    req = 1'b0;
    r_w_type = 1'b0;
    addr = '0;
    write_data = '0;
    fill_wbuf_random();

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("after_reset");

    // Reset two cycles after a request is accepted, while still waiting.
    run_block(RD, 10'h3A4, 1'b0, 1'b0, 2);

    // Fill every block with known data; some transfers see a noisy request line.
    for (int b = 0; b < 64; b++) begin
      fill_wbuf_random();
      run_block(WR, {b[5:0], 4'($urandom)}, 1'b1, (b % 3) == 0, -1);
    end
    req = 1'b0;
    @(posedge clk);
    #1;

    wbuf[0] = 32'h11;
    wbuf[1] = 32'h22;
    wbuf[2] = 32'h33;
    wbuf[3] = 32'h44;
    run_block(WR, 10'h3A0, 1'b0, 1'b0, -1);
    run_block(RD, 10'h3A4, 1'b0, 1'b0, -1);

    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h1;
    wbuf[2] = 32'h2;
    wbuf[3] = 32'h3;
    run_block(WR, 10'h050, 1'b0, 1'b0, -1);
    run_block(RD, 10'h050, 1'b0, 1'b0, -1);
    run_block(RD, 10'h040, 1'b0, 1'b0, -1);

    // Held request: back-to-back transfers with one idle cycle between them.
    for (int i = 0; i < 6; i++) begin
      fill_wbuf_random();
      run_block(1'($urandom_range(0, 1)), 10'($urandom), 1'b1, 1'b1, -1);
    end
    req = 1'b0;
    @(posedge clk);
    #1;

    // Reset during a write-back while word 2 is being presented.
    fill_wbuf_random();
    run_block(WR, 10'h020, 1'b0, 1'b0, int'(LAT) + 2);
    run_block(RD, 10'h020, 1'b0, 1'b0, -1);

    for (int i = 0; i < 16; i++) begin
      fill_wbuf_random();
      run_block(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
